// File: rtl/lock_pkg.sv
// Shared types and helpers for the parametrised digital lock.
package lock_pkg;

    // Raw state encodings, kept visible so other tools can decode the state bus.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ENTRY   = 2'd1;
    localparam logic [1:0] ST_OPEN    = 2'd2;
    localparam logic [1:0] ST_LOCKOUT = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ENTRY   = ST_ENTRY,
        OPEN    = ST_OPEN,
        LOCKOUT = ST_LOCKOUT
    } lock_state_t;

    // Largest of three durations; sizes the shared timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter shared by the open window, lockout and entry idle timing.
// Counts down once per cycle, sticks at zero and never wraps.
module lock_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: a load wins, otherwise decrement until zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/param_digital_lock.sv
// Parametrised digital lock: collects CODE_LEN symbols, compares against a
// reloadable code, opens for a timed window and locks out after repeated failures.
// Optional feature: define LOCK_TIMEOUT_EN to abort an entry after ENTRY_TIMEOUT
// idle cycles (counted as a failed attempt).
module param_digital_lock
    import lock_pkg::*;
#(
    parameter int                          KEY_W          = 1,
    parameter int                          CODE_LEN       = 4,
    parameter logic [CODE_LEN*KEY_W-1:0]   DEFAULT_CODE   = 4'b1101,
    parameter int                          MAX_FAILS      = 3,
    parameter int                          OPEN_CYCLES    = 8,
    parameter int                          LOCKOUT_CYCLES = 16,
    parameter int                          ENTRY_TIMEOUT  = 32
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                key_valid,
    input  logic [KEY_W-1:0]                    key_in,
    input  logic                                code_load,
    input  logic [CODE_LEN*KEY_W-1:0]           code_in,
    output logic                                unlock,
    output logic                                locked_out,
    output logic [$clog2(MAX_FAILS+1)-1:0]      fail_cnt,
    output logic                                attempt_err
);

    localparam int CODE_W = CODE_LEN * KEY_W;
    localparam int IDX_W  = cnt_width(CODE_LEN);
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int TMR_W  = cnt_width(max3(OPEN_CYCLES, LOCKOUT_CYCLES, ENTRY_TIMEOUT));

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_FAILS - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX  = FAIL_W'(MAX_FAILS);
    localparam logic [TMR_W-1:0]  OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
    localparam logic [TMR_W-1:0]  LOCK_LOAD = TMR_W'(LOCKOUT_CYCLES - 1);
`ifdef LOCK_TIMEOUT_EN
    localparam logic [TMR_W-1:0]  IDLE_LOAD = TMR_W'(ENTRY_TIMEOUT - 1);
`endif

    lock_state_t        state_q,       state_d;
    logic [CODE_W-1:0]  entry_q,       entry_d;
    logic [IDX_W-1:0]   idx_q,         idx_d;
    logic [CODE_W-1:0]  code_q,        code_d;
    logic [FAIL_W-1:0]  fail_cnt_q,    fail_cnt_d;
    logic               attempt_err_q, attempt_err_d;

    logic [CODE_W-1:0]  shifted;
    logic               entry_pass;
    logic               entry_fail;
    logic               timer_load;
    logic [TMR_W-1:0]   timer_load_val;
    logic               timer_zero;

    lock_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (timer_load),
        .load_val (timer_load_val),
        .zero     (timer_zero)
    );

    // Next-state logic: symbol collection, evaluation, open/lockout timing and code reload.
    always_comb begin
        state_d        = state_q;
        entry_d        = entry_q;
        idx_d          = idx_q;
        code_d         = code_q;
        fail_cnt_d     = fail_cnt_q;
        attempt_err_d  = 1'b0;
        timer_load     = 1'b0;
        timer_load_val = '0;
        entry_pass     = 1'b0;
        entry_fail     = 1'b0;

        shifted             = entry_q << KEY_W;
        shifted[KEY_W-1:0]  = key_in;

        case (state_q)
            IDLE, ENTRY: begin
                if (key_valid) begin
                    entry_d = shifted;
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        if (shifted == code_q) begin
                            entry_pass = 1'b1;
                        end else begin
                            entry_fail = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ENTRY;
`ifdef LOCK_TIMEOUT_EN
                        timer_load     = 1'b1;
                        timer_load_val = IDLE_LOAD;
`endif
                    end
                end
`ifdef LOCK_TIMEOUT_EN
                else if (state_q == ENTRY && timer_zero) begin
                    idx_d      = '0;
                    entry_fail = 1'b1;
                end
`endif
            end
            OPEN: begin
                if (code_load) begin
                    code_d = code_in;
                end
                if (timer_zero) begin
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (timer_zero) begin
                    state_d    = IDLE;
                    fail_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (entry_pass) begin
            state_d        = OPEN;
            fail_cnt_d     = '0;
            timer_load     = 1'b1;
            timer_load_val = OPEN_LOAD;
        end else if (entry_fail) begin
            attempt_err_d = 1'b1;
            fail_cnt_d    = (fail_cnt_q == FAIL_MAX) ? FAIL_MAX : fail_cnt_q + FAIL_W'(1);
            if (fail_cnt_q == FAIL_LAST) begin
                state_d        = LOCKOUT;
                timer_load     = 1'b1;
                timer_load_val = LOCK_LOAD;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State and datapath registers; reset discards any entry and restores the default code.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            entry_q       <= '0;
            idx_q         <= '0;
            code_q        <= DEFAULT_CODE;
            fail_cnt_q    <= '0;
            attempt_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            entry_q       <= entry_d;
            idx_q         <= idx_d;
            code_q        <= code_d;
            fail_cnt_q    <= fail_cnt_d;
            attempt_err_q <= attempt_err_d;
        end
    end

    assign unlock      = (state_q == OPEN);
    assign locked_out  = (state_q == LOCKOUT);
    assign fail_cnt    = fail_cnt_q;
    assign attempt_err = attempt_err_q;

endmodule
